// File: rtl/can_pkg.sv
// Shared types for the CAN receive frame assembler: frame record layout and assembly FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a. Optional timestamp field selected by CAN_RX_TIMESTAMP_EN.
package can_pkg;

  localparam int CAN_MAX_BYTES = 8;
  localparam int CAN_ID_W      = 29;
  localparam int CAN_TS_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_COMMIT  = 2'd2
  } can_asm_state_t;

  typedef struct packed {
    logic                         ide;
    logic [CAN_ID_W-1:0]          id;
    logic [3:0]                   len;
    logic                         err;
    logic [8*CAN_MAX_BYTES-1:0]   data;
`ifdef CAN_RX_TIMESTAMP_EN
    logic [CAN_TS_W-1:0]          timestamp;
`endif
  } can_frame_rec_t;

endpackage

// File: rtl/can_frame_fifo.sv
// Synchronous first-word-fall-through FIFO of frame records; head visible on pop_dat whenever !empty.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push ignored when full unless a pop happens in the same cycle; pop ignored when empty.
// Ports: clk, rst (sync, active-high), push/push_dat, pop/pop_dat, empty, full, level (0..2**AW).
module can_frame_fifo #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  pop_dat,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   level
);

  logic [W-1:0] mem [0:(1<<AW)-1];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         do_push;
  logic         do_pop;

  // Pointers carry one extra wrap bit: equal -> empty, only the MSB differs -> full.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  // When full, a same-cycle pop frees the slot being written (head is read before the edge).
  assign do_push = push && (!full || do_pop);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

endmodule

// File: rtl/can_rx_frame_assembler.sv
// Packs the CAN receive byte stream into frame records and queues them for the host over valid/ready.
// Latency: rx_last byte sampled -> record on m_valid 2 clk later (one COMMIT cycle + FIFO write).
// Backpressure: byte stream cannot stall; whole frames are dropped (drop_cnt, saturating) when the queue is full.
// Ports: clk, rst (sync, active-high); rx_valid/rx_last/rx_data/rx_id/rx_ide byte stream in;
//        m_valid/m_ready/m_id/m_ide/m_len/m_data/m_err record out; fifo_level, drop_cnt status.
// Build option CAN_RX_TIMESTAMP_EN adds a free-running cycle counter and the m_timestamp output.
module can_rx_frame_assembler
  import can_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int DROP_CW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic                    rx_last,
  input  logic [7:0]              rx_data,
  input  logic [CAN_ID_W-1:0]     rx_id,
  input  logic                    rx_ide,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [CAN_ID_W-1:0]     m_id,
  output logic                    m_ide,
  output logic [3:0]              m_len,
  output logic [63:0]             m_data,
  output logic                    m_err,
  output logic [FIFO_AW:0]        fifo_level,
  output logic [DROP_CW-1:0]      drop_cnt
`ifdef CAN_RX_TIMESTAMP_EN
  ,
  output logic [CAN_TS_W-1:0]     m_timestamp
`endif
);

  can_asm_state_t              state;
  can_asm_state_t              state_nxt;
  logic [3:0]                  cnt;
  logic [8*CAN_MAX_BYTES-1:0]  asm_data;
  logic [CAN_ID_W-1:0]         asm_id;
  logic                        asm_ide;
  logic                        asm_err;
  logic                        frame_start;
  logic                        commit;
  logic                        pop;
  logic                        push_ok;
  logic                        fifo_empty;
  logic                        fifo_full;
  can_frame_rec_t              push_rec;
  can_frame_rec_t              head_rec;
  can_frame_rec_t              out_rec;

`ifdef CAN_RX_TIMESTAMP_EN
  logic [CAN_TS_W-1:0]         ts_cnt;
  logic [CAN_TS_W-1:0]         asm_ts;

  always_ff @(posedge clk) begin
    if (rst) ts_cnt <= '0;
    else     ts_cnt <= ts_cnt + CAN_TS_W'(1);
  end
`endif

  // Any byte outside COLLECT opens a new frame, including one arriving during COMMIT.
  assign frame_start = rx_valid && (state != ST_COLLECT);
  assign commit      = (state == ST_COMMIT);
  assign pop         = m_valid && m_ready;
  assign push_ok     = commit && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_COLLECT: begin
        if (rx_valid && rx_last) state_nxt = ST_COMMIT;
      end
      default: begin
        if (rx_valid) state_nxt = rx_last ? ST_COMMIT : ST_COLLECT;
        else          state_nxt = ST_IDLE;
      end
    endcase
  end

  // Byte packing. cnt saturates at 8, so it doubles as the record length.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      asm_data <= '0;
      asm_id   <= '0;
      asm_ide  <= 1'b0;
      asm_err  <= 1'b0;
`ifdef CAN_RX_TIMESTAMP_EN
      asm_ts   <= '0;
`endif
    end else if (rx_valid) begin
      if (frame_start) begin
        asm_data <= {{(8*CAN_MAX_BYTES-8){1'b0}}, rx_data};
        asm_id   <= rx_id;
        asm_ide  <= rx_ide;
        asm_err  <= 1'b0;
        cnt      <= 4'd1;
`ifdef CAN_RX_TIMESTAMP_EN
        asm_ts   <= ts_cnt;
`endif
      end else if (cnt < 4'd8) begin
        asm_data[8*cnt +: 8] <= rx_data;
        cnt                  <= cnt + 4'd1;
      end else begin
        asm_err <= 1'b1;
      end
    end
  end

  always_comb begin
    push_rec      = '0;
    push_rec.ide  = asm_ide;
    push_rec.id   = asm_id;
    push_rec.len  = cnt;
    push_rec.err  = asm_err;
    push_rec.data = asm_data;
`ifdef CAN_RX_TIMESTAMP_EN
    push_rec.timestamp = asm_ts;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (commit && !push_ok && (drop_cnt != '1)) begin
      drop_cnt <= drop_cnt + DROP_CW'(1);
    end
  end

  can_frame_fifo #(
    .W  ($bits(can_frame_rec_t)),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_ok),
    .push_dat (push_rec),
    .pop      (pop),
    .pop_dat  (head_rec),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .level    (fifo_level)
  );

  // Record memory is not reset; zero the outputs while nothing is queued.
  assign m_valid = !fifo_empty;
  assign out_rec = m_valid ? head_rec : '0;
  assign m_id    = out_rec.id;
  assign m_ide   = out_rec.ide;
  assign m_len   = out_rec.len;
  assign m_data  = out_rec.data;
  assign m_err   = out_rec.err;
`ifdef CAN_RX_TIMESTAMP_EN
  assign m_timestamp = out_rec.timestamp;
`endif

endmodule

// File: tb/tb_can_rx_frame_assembler.sv
// Directed self-checking bench for can_rx_frame_assembler.
// Inputs driven and outputs sampled on the falling clock edge.
// Timestamp checks compile in only when CAN_RX_TIMESTAMP_EN is defined.
module tb_can_rx_frame_assembler;

  logic        clk = 1'b0;
  logic        rst;
  logic        rx_valid;
  logic        rx_last;
  logic [7:0]  rx_data;
  logic [28:0] rx_id;
  logic        rx_ide;
  logic        m_valid;
  logic        m_ready;
  logic [28:0] m_id;
  logic        m_ide;
  logic [3:0]  m_len;
  logic [63:0] m_data;
  logic        m_err;
  logic [4:0]  fifo_level;
  logic [15:0] drop_cnt;
`ifdef CAN_RX_TIMESTAMP_EN
  logic [31:0] m_timestamp;
`endif

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [7:0]  tx_q [$];

  always #5 clk = ~clk;

  can_rx_frame_assembler #(.FIFO_AW(4), .DROP_CW(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid    (rx_valid),
    .rx_last     (rx_last),
    .rx_data     (rx_data),
    .rx_id       (rx_id),
    .rx_ide      (rx_ide),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_id        (m_id),
    .m_ide       (m_ide),
    .m_len       (m_len),
    .m_data      (m_data),
    .m_err       (m_err),
    .fifo_level  (fifo_level),
    .drop_cnt    (drop_cnt)
`ifdef CAN_RX_TIMESTAMP_EN
    ,
    .m_timestamp (m_timestamp)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Sends tx_q as one frame, one byte per cycle; term=0 leaves the frame open.
  // Called and returns on a falling edge; on return the last byte has been sampled.
  task automatic send_frame(input logic [28:0] id, input logic ide, input logic term);
    for (int k = 0; k < tx_q.size(); k++) begin
      rx_valid = 1'b1;
      rx_last  = term && (k == tx_q.size() - 1);
      rx_data  = tx_q[k];
      rx_id    = id;
      rx_ide   = ide;
      @(negedge clk);
    end
    rx_valid = 1'b0;
    rx_last  = 1'b0;
    rx_id    = 29'h1fff_ffff;
  endtask

  task automatic pop_one();
    m_ready = 1'b1;
    @(negedge clk);
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_last = 1'b0; rx_data = '0;
    rx_id = '0; rx_ide = 1'b0; m_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_level",   64'(fifo_level), 64'd0);
    chk("rst_drop",    64'(drop_cnt), 64'd0);
    chk("rst_m_data",  m_data, 64'd0);

    // T1: 8-byte standard frame
    tx_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame(29'h123, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t1_valid", 64'(m_valid), 64'd1);
    chk("t1_id",    64'(m_id), 64'h123);
    chk("t1_ide",   64'(m_ide), 64'd0);
    chk("t1_len",   64'(m_len), 64'd8);
    chk("t1_data",  m_data, 64'h0807060504030201);
    chk("t1_err",   64'(m_err), 64'd0);
    @(negedge clk);
    chk("t1_hold_data", m_data, 64'h0807060504030201);
    pop_one();
    chk("t1_empty", 64'(m_valid), 64'd0);
    chk("t1_level", 64'(fifo_level), 64'd0);

    // T2: 1-byte extended frame, latency check
    tx_q = '{8'hAA};
    send_frame(29'h12345678, 1'b1, 1'b1);
    chk("t2_valid_1clk", 64'(m_valid), 64'd0);
    @(negedge clk);
    chk("t2_valid_2clk", 64'(m_valid), 64'd1);
    chk("t2_id",   64'(m_id), 64'h12345678);
    chk("t2_ide",  64'(m_ide), 64'd1);
    chk("t2_len",  64'(m_len), 64'd1);
    chk("t2_data", m_data, 64'hAA);
    pop_one();

    // T3: 17 back-to-back frames with no consumer -> 16 queued, 1 dropped
    for (int i = 1; i <= 17; i++) begin
      tx_q = '{8'(i)};
      send_frame(29'(i), 1'b0, 1'b1);
    end
    repeat (2) @(negedge clk);
    chk("t3_level", 64'(fifo_level), 64'd16);
    chk("t3_drop",  64'(drop_cnt), 64'd1);
    m_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      chk("t3_pop_id",   64'(m_id), 64'(i));
      chk("t3_pop_data", m_data, 64'(i));
      @(negedge clk);
    end
    m_ready = 1'b0;
    chk("t3_empty", 64'(m_valid), 64'd0);
    chk("t3_level_end", 64'(fifo_level), 64'd0);

    // T4: 10 bytes -> truncated to 8 with err
    tx_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h18, 8'h19};
    send_frame(29'h7ff, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t4_len",  64'(m_len), 64'd8);
    chk("t4_err",  64'(m_err), 64'd1);
    chk("t4_data", m_data, 64'h1716151413121110);
    pop_one();

    // T5: reset mid-frame, then a clean 2-byte frame
    tx_q = '{8'h51, 8'h52, 8'h53};
    send_frame(29'h55, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tx_q = '{8'h11, 8'h22};
    send_frame(29'h66, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t5_level", 64'(fifo_level), 64'd1);
    chk("t5_len",   64'(m_len), 64'd2);
    chk("t5_data",  m_data, 64'h2211);
    chk("t5_id",    64'(m_id), 64'h66);
    pop_one();
    chk("t5_empty", 64'(m_valid), 64'd0);

    // T6: full FIFO with a pop on the commit cycle -> no drop
    for (int i = 0; i < 16; i++) begin
      tx_q = '{8'(8'h40 + i)};
      send_frame(29'(i), 1'b0, 1'b1);
    end
    repeat (2) @(negedge clk);
    chk("t6_full_level", 64'(fifo_level), 64'd16);
    tx_q = '{8'h99};
    send_frame(29'h99, 1'b0, 1'b1);
    pop_one();
    chk("t6_level", 64'(fifo_level), 64'd16);
    chk("t6_drop",  64'(drop_cnt), 64'd0);
    chk("t6_head",  m_data, 64'h41);
    m_ready = 1'b1;
    repeat (15) @(negedge clk);
    m_ready = 1'b0;
    chk("t6_tail", m_data, 64'h99);
    pop_one();
    chk("t6_empty", 64'(m_valid), 64'd0);

`ifdef CAN_RX_TIMESTAMP_EN
    // Counter reads 0 after the reset edge; byte sampled 101 edges later sees 100.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    tx_q = '{8'h5A};
    send_frame(29'h5A, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    chk("t6_ts_valid", 64'(m_valid), 64'd1);
    chk("t6_ts", 64'(m_timestamp), 64'd100);
    pop_one();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
